// File: rtl/affine_tex_walker.sv
// Per-pixel affine texel-coordinate walker. Texel index is valid one cycle after px_en; cfg_ready drops while a set is pending.
// Define AFFINE_TEX_WALKER_MIRROR_EN for mirrored-repeat addressing instead of plain tiling.
module affine_tex_walker #(
  parameter int COORD_W  = 24,
  parameter int FRAC_W   = 16,
  parameter int TEX_LOG2 = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [COORD_W-1:0]  cfg_u0,
  input  logic [COORD_W-1:0]  cfg_v0,
  input  logic [COORD_W-1:0]  cfg_du_dx,
  input  logic [COORD_W-1:0]  cfg_dv_dx,
  input  logic [COORD_W-1:0]  cfg_du_dy,
  input  logic [COORD_W-1:0]  cfg_dv_dy,
  input  logic                frame_start,
  input  logic                line_start,
  input  logic                px_en,
  output logic [TEX_LOG2-1:0] tex_u,
  output logic [TEX_LOG2-1:0] tex_v,
  output logic                tex_valid,
  output logic                busy
);

`ifdef AFFINE_TEX_WALKER_MIRROR_EN
  localparam int IDX_HI = FRAC_W + TEX_LOG2;
`else
  localparam int IDX_HI = FRAC_W + TEX_LOG2 - 1;
`endif

  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nxt;

  logic               pending;
  logic [COORD_W-1:0] sh_u0, sh_v0, sh_du_dx, sh_dv_dx, sh_du_dy, sh_dv_dy;
  logic [COORD_W-1:0] act_u0, act_v0, act_du_dx, act_dv_dx, act_du_dy, act_dv_dy;
  logic [COORD_W-1:0] row_u, row_v, u, v;

  logic               cfg_fire, commit, reload, run_eff;
  logic [COORD_W-1:0] e_du_dx, e_dv_dx, e_du_dy, e_dv_dy, e_row_u, e_row_v;
  logic [IDX_HI:FRAC_W] pix_u, pix_v;
  logic [TEX_LOG2-1:0]  idx_u, idx_v;

  assign cfg_ready = !pending;
  assign busy      = (state == RUN);
  assign cfg_fire  = cfg_valid && !pending;
  assign commit    = frame_start && pending;
  assign reload    = frame_start && !pending && (state == RUN);
  // A commit coinciding with line_start must already drive this line.
  assign run_eff   = (state == RUN) || commit;

  always_comb begin
    state_nxt = state;
    if (commit) state_nxt = RUN;
  end

  always_comb begin
    e_du_dx = commit ? sh_du_dx : act_du_dx;
    e_dv_dx = commit ? sh_dv_dx : act_dv_dx;
    e_du_dy = commit ? sh_du_dy : act_du_dy;
    e_dv_dy = commit ? sh_dv_dy : act_dv_dy;
    e_row_u = row_u;
    e_row_v = row_v;
    if (commit) begin
      e_row_u = sh_u0;
      e_row_v = sh_v0;
    end else if (reload) begin
      e_row_u = act_u0;
      e_row_v = act_v0;
    end
    pix_u = line_start ? e_row_u[IDX_HI:FRAC_W] : u[IDX_HI:FRAC_W];
    pix_v = line_start ? e_row_v[IDX_HI:FRAC_W] : v[IDX_HI:FRAC_W];
`ifdef AFFINE_TEX_WALKER_MIRROR_EN
    idx_u = pix_u[IDX_HI] ? ~pix_u[IDX_HI-1:FRAC_W] : pix_u[IDX_HI-1:FRAC_W];
    idx_v = pix_v[IDX_HI] ? ~pix_v[IDX_HI-1:FRAC_W] : pix_v[IDX_HI-1:FRAC_W];
`else
    idx_u = pix_u;
    idx_v = pix_v;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending   <= 1'b0;
      sh_u0     <= '0; sh_v0     <= '0; sh_du_dx  <= '0;
      sh_dv_dx  <= '0; sh_du_dy  <= '0; sh_dv_dy  <= '0;
      act_u0    <= '0; act_v0    <= '0; act_du_dx <= '0;
      act_dv_dx <= '0; act_du_dy <= '0; act_dv_dy <= '0;
      row_u     <= '0; row_v     <= '0;
      u         <= '0; v         <= '0;
      tex_u     <= '0; tex_v     <= '0;
      tex_valid <= 1'b0;
    end else begin
      if (cfg_fire) begin
        sh_u0    <= cfg_u0;    sh_v0    <= cfg_v0;
        sh_du_dx <= cfg_du_dx; sh_dv_dx <= cfg_dv_dx;
        sh_du_dy <= cfg_du_dy; sh_dv_dy <= cfg_dv_dy;
        pending  <= 1'b1;
      end else if (commit) begin
        pending  <= 1'b0;
      end
      if (commit) begin
        act_u0    <= sh_u0;    act_v0    <= sh_v0;
        act_du_dx <= sh_du_dx; act_dv_dx <= sh_dv_dx;
        act_du_dy <= sh_du_dy; act_dv_dy <= sh_dv_dy;
      end
      tex_valid <= 1'b0;
      if (run_eff) begin
        if (line_start) begin
          row_u <= e_row_u + e_du_dy;
          row_v <= e_row_v + e_dv_dy;
          u     <= px_en ? e_row_u + e_du_dx : e_row_u;
          v     <= px_en ? e_row_v + e_dv_dx : e_row_v;
        end else begin
          row_u <= e_row_u;
          row_v <= e_row_v;
          if (px_en) begin
            u <= u + e_du_dx;
            v <= v + e_dv_dx;
          end
        end
        if (px_en) begin
          tex_valid <= 1'b1;
          tex_u     <= idx_u;
          tex_v     <= idx_v;
        end
      end
    end
  end

endmodule

// File: tb/tb_affine_tex_walker.sv
// Directed self-checking bench for affine_tex_walker (default 24/16/5 parameters).
module tb_affine_tex_walker;
  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [23:0] cfg_u0, cfg_v0, cfg_du_dx, cfg_dv_dx, cfg_du_dy, cfg_dv_dy;
  logic        frame_start, line_start, px_en;
  logic [4:0]  tex_u, tex_v;
  logic        tex_valid, busy;

  int errors = 0;
  int checks = 0;

  affine_tex_walker dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_u0(cfg_u0), .cfg_v0(cfg_v0), .cfg_du_dx(cfg_du_dx), .cfg_dv_dx(cfg_dv_dx),
    .cfg_du_dy(cfg_du_dy), .cfg_dv_dy(cfg_dv_dy), .frame_start(frame_start),
    .line_start(line_start), .px_en(px_en), .tex_u(tex_u), .tex_v(tex_v),
    .tex_valid(tex_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input logic [23:0] u0, v0, dudx, dvdx, dudy, dvdy);
    cfg_u0 = u0; cfg_v0 = v0; cfg_du_dx = dudx; cfg_dv_dx = dvdx;
    cfg_du_dy = dudy; cfg_dv_dy = dvdy;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; px_en = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++; if (tex_valid !== 1'b0) begin errors++; $display("FAIL reset_tex_valid got %b want 0", tex_valid); end
    checks++; if (tex_u !== 5'd0 || tex_v !== 5'd0) begin errors++; $display("FAIL reset_tex got u=%0d v=%0d want 0 0", tex_u, tex_v); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready got %b want 1", cfg_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    px_en = 1'b0;
  endtask

  task automatic test_half_step();
    logic [4:0] exp_u [4] = '{5'd0, 5'd0, 5'd1, 5'd1};
    do_cfg(24'h0, 24'h0, 24'h008000, 24'h0, 24'h0, 24'h0);
    pulse_frame();
    checks++; if (busy !== 1'b1 || cfg_ready !== 1'b1) begin errors++; $display("FAIL half_commit got busy=%b rdy=%b want 1 1", busy, cfg_ready); end
    for (int i = 0; i < 4; i++) begin
      line_start = (i == 0); px_en = 1'b1;
      tick();
      checks++;
      if (tex_valid !== 1'b1 || tex_u !== exp_u[i] || tex_v !== 5'd0) begin
        errors++; $display("FAIL half_px%0d got vld=%b u=%0d v=%0d want 1 %0d 0", i, tex_valid, tex_u, tex_v, exp_u[i]);
      end
    end
    line_start = 1'b0; px_en = 1'b0;
    tick();
    checks++; if (tex_valid !== 1'b0 || tex_u !== 5'd1) begin errors++; $display("FAIL half_hold got vld=%b u=%0d want 0 1", tex_valid, tex_u); end
  endtask

  task automatic test_line_step();
    do_cfg(24'h0, 24'h0, 24'h010000, 24'h0, 24'h0, 24'h010000);
    pulse_frame();
    for (int ln = 0; ln < 2; ln++) begin
      for (int i = 0; i < 3; i++) begin
        line_start = (i == 0); px_en = 1'b1;
        tick();
        checks++;
        if (tex_valid !== 1'b1 || tex_u !== 5'(i) || tex_v !== 5'(ln)) begin
          errors++; $display("FAIL line%0d_px%0d got vld=%b u=%0d v=%0d want 1 %0d %0d", ln, i, tex_valid, tex_u, tex_v, i, ln);
        end
      end
      line_start = 1'b0; px_en = 1'b0;
      tick();
    end
  endtask

  task automatic test_wrap();
`ifdef AFFINE_TEX_WALKER_MIRROR_EN
    logic [4:0] exp_u [3] = '{5'd31, 5'd31, 5'd30};
    logic [4:0] exp_n [2] = '{5'd0, 5'd0};
`else
    logic [4:0] exp_u [3] = '{5'd31, 5'd0, 5'd1};
    logic [4:0] exp_n [2] = '{5'd31, 5'd0};
`endif
    do_cfg(24'h1F0000, 24'h0, 24'h010000, 24'h0, 24'h0, 24'h0);
    pulse_frame();
    for (int i = 0; i < 3; i++) begin
      line_start = (i == 0); px_en = 1'b1;
      tick();
      checks++; if (tex_u !== exp_u[i]) begin errors++; $display("FAIL wrap_px%0d got u=%0d want %0d", i, tex_u, exp_u[i]); end
    end
    line_start = 1'b0; px_en = 1'b0;
    // u0 = -1.0: negative coordinates and 24-bit modulo wrap to 0
    do_cfg(24'hFF0000, 24'h0, 24'h010000, 24'h0, 24'h0, 24'h0);
    pulse_frame();
    for (int i = 0; i < 2; i++) begin
      line_start = (i == 0); px_en = 1'b1;
      tick();
      checks++; if (tex_u !== exp_n[i]) begin errors++; $display("FAIL neg_px%0d got u=%0d want %0d", i, tex_u, exp_n[i]); end
    end
    line_start = 1'b0; px_en = 1'b0;
    tick();
  endtask

  task automatic line_px_check(input string name, input logic [4:0] want);
    line_start = 1'b1; px_en = 1'b1;
    tick();
    line_start = 1'b0; px_en = 1'b0;
    checks++; if (tex_valid !== 1'b1 || tex_u !== want) begin errors++; $display("FAIL %s got vld=%b u=%0d want 1 %0d", name, tex_valid, tex_u, want); end
  endtask

  task automatic test_shadow();
    do_cfg(24'h030000, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0);
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL shadow_pending got rdy=%b want 0", cfg_ready); end
    do_cfg(24'h070000, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0);
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL shadow_ignored got rdy=%b want 0", cfg_ready); end
    pulse_frame();
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL shadow_commit got rdy=%b want 1", cfg_ready); end
    line_px_check("shadow_A_active", 5'd3);
    cfg_u0 = 24'h070000; cfg_valid = 1'b1; frame_start = 1'b1;
    tick();
    cfg_valid = 1'b0; frame_start = 1'b0;
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL shadow_B_pending got rdy=%b want 0", cfg_ready); end
    line_px_check("shadow_A_kept", 5'd3);
    pulse_frame();
    line_px_check("shadow_B_commit", 5'd7);
  endtask

  task automatic test_reset_midline();
    line_start = 1'b1; px_en = 1'b1;
    tick();
    line_start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (tex_valid !== 1'b0 || tex_u !== 5'd0 || busy !== 1'b0 || cfg_ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid got vld=%b u=%0d busy=%b rdy=%b want 0 0 0 1", tex_valid, tex_u, busy, cfg_ready);
    end
    frame_start = 1'b1; line_start = 1'b1;
    tick();
    frame_start = 1'b0; line_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (tex_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_idle%0d got vld=%b busy=%b want 0 0", i, tex_valid, busy); end
    end
    px_en = 1'b0;
    // commit, line start and first pixel all in one cycle
    do_cfg(24'h050000, 24'h020000, 24'h0, 24'h0, 24'h0, 24'h0);
    frame_start = 1'b1; line_start = 1'b1; px_en = 1'b1;
    tick();
    frame_start = 1'b0; line_start = 1'b0; px_en = 1'b0;
    checks++; if (tex_valid !== 1'b1 || tex_u !== 5'd5 || tex_v !== 5'd2 || busy !== 1'b1) begin
      errors++; $display("FAIL rst_recover got vld=%b u=%0d v=%0d busy=%b want 1 5 2 1", tex_valid, tex_u, tex_v, busy);
    end
  endtask

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; frame_start = 1'b0; line_start = 1'b0; px_en = 1'b0;
    cfg_u0 = '0; cfg_v0 = '0; cfg_du_dx = '0; cfg_dv_dx = '0; cfg_du_dy = '0; cfg_dv_dy = '0;
    test_reset();
    test_half_step();
    test_line_step();
    test_wrap();
    test_shadow();
    test_reset_midline();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
